ulbf_dout_axis2ram_64b: RTL and testbench

ULBF_DOUT_AXIS2RAM_64B -- requirements
Module: ulbf_dout_axis2ram_64b

---
 rtl/ulbf_dout_pkg.sv | 13 +
 rtl/ulbf_dout_sdp_ram.sv | 43 ++++
 rtl/ulbf_dout_axis2ram_64b.sv | 170 +++++++++++++++++
 tb/tb_ulbf_dout_axis2ram_64b.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulbf_dout_pkg.sv
// Shared types and widths for the ULBF dout AXI-Stream-to-RAM capture block.
package ulbf_dout_pkg;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ulbf_dout_state_t;

endpackage : ulbf_dout_pkg

// File: rtl/ulbf_dout_sdp_ram.sv
// Simple dual-port capture RAM: byte-enabled write port, read-first read
// port with one cycle of latency. Only the read register is reset.
module ulbf_dout_sdp_ram #(
    parameter int DEPTH = 2048,
    parameter int DW    = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW/8-1:0] wbe,
    input  logic [DW-1:0]   wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem_r [0:DEPTH-1];

    // Byte-lane write; array is left unreset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DW/8; i++) begin
                if (wbe[i]) begin
                    mem_r[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Registered read; nonblocking semantics give old data on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_r[raddr];
        end else begin
            rdata <= rdata;
        end
    end

endmodule : ulbf_dout_sdp_ram

// File: rtl/ulbf_dout_axis2ram_64b.sv
// Captures niter blocks of block_size AXI-Stream beats into a local RAM,
// wrapping the write address at rollover_addr or the end of the RAM.
// Optional feature: define ULBF_TLAST_CHECK_EN to count tlast mismatches.
module ulbf_dout_axis2ram_64b
    import ulbf_dout_pkg::*;
#(
    parameter int RAM_DEPTH  = 2048,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    s_axis_clk,
    input  logic                    s_axis_rst,
    input  logic                    go,
    input  logic [CNT_W-1:0]        niter,
    input  logic [CNT_W-1:0]        block_size,
    input  logic [ADDR_W-1:0]       rollover_addr,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    output logic                    s_axis_tready,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [63:0]             rd_data,
    output logic                    done,
    output logic [ADDR_W-1:0]       addr_wire,
    output logic [15:0]             tlast_err_cnt
);

    localparam int                RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    ulbf_dout_state_t    state_r;
    logic                tready_r;
    logic                done_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   roll_r;
    logic [CNT_W-1:0]    niter_r;
    logic [CNT_W-1:0]    bsize_r;
    logic [CNT_W-1:0]    beat_cnt_r;
    logic [CNT_W-1:0]    blk_cnt_r;
    logic                accept_s;
    logic                start_s;
    logic                last_beat_s;
    logic                last_blk_s;
    logic [ADDR_W-1:0]   addr_nxt_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;
    logic                unused_s;

    assign accept_s = s_axis_tvalid & tready_r;
    assign start_s  = (state_r == ST_IDLE) & go &
                      (niter != {CNT_W{1'b0}}) & (block_size != {CNT_W{1'b0}});

    // Beat/block terminal flags and next write address with both wrap points.
    always_comb begin
        last_beat_s = (beat_cnt_r == (bsize_r - CNT_W'(1)));
        last_blk_s  = (blk_cnt_r == (niter_r - CNT_W'(1)));
        if ((addr_r == roll_r) || (addr_r == LAST_ADDR)) begin
            addr_nxt_s = {ADDR_W{1'b0}};
        end else begin
            addr_nxt_s = addr_r + ADDR_W'(1);
        end
    end

    // Capture FSM with registered tready/done and beat/block counters.
    always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
        if (s_axis_rst) begin
            state_r    <= ST_IDLE;
            tready_r   <= 1'b0;
            done_r     <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            roll_r     <= {ADDR_W{1'b0}};
            niter_r    <= {CNT_W{1'b0}};
            bsize_r    <= {CNT_W{1'b0}};
            beat_cnt_r <= {CNT_W{1'b0}};
            blk_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r    <= ST_RUN;
                        tready_r   <= 1'b1;
                        niter_r    <= niter;
                        bsize_r    <= block_size;
                        roll_r     <= rollover_addr;
                        beat_cnt_r <= {CNT_W{1'b0}};
                        blk_cnt_r  <= {CNT_W{1'b0}};
                    end else if (go) begin
                        // Empty request: report completion without accepting beats.
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        addr_r <= addr_nxt_s;
                        if (last_beat_s) begin
                            beat_cnt_r <= {CNT_W{1'b0}};
                            if (last_blk_s) begin
                                state_r  <= ST_DONE;
                                tready_r <= 1'b0;
                                done_r   <= 1'b1;
                            end else begin
                                blk_cnt_r <= blk_cnt_r + CNT_W'(1);
                            end
                        end else begin
                            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!go) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                        addr_r  <= {ADDR_W{1'b0}};
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    tready_r <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

`ifdef ULBF_TLAST_CHECK_EN
    logic [15:0] tlast_err_r;

    // Saturating count of beats whose tlast disagrees with the block boundary.
    always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
        if (s_axis_rst) begin
            tlast_err_r <= 16'h0000;
        end else if (start_s) begin
            tlast_err_r <= 16'h0000;
        end else if (accept_s && (s_axis_tlast != last_beat_s) && (tlast_err_r != 16'hFFFF)) begin
            tlast_err_r <= tlast_err_r + 16'h0001;
        end else begin
            tlast_err_r <= tlast_err_r;
        end
    end

    assign tlast_err_cnt = tlast_err_r;
    assign unused_s      = ^{rd_addr, addr_r};
`else
    assign tlast_err_cnt = 16'h0000;
    assign unused_s      = ^{rd_addr, addr_r, s_axis_tlast};
`endif

    ulbf_dout_sdp_ram #(
        .DEPTH (RAM_DEPTH),
        .DW    (DATA_WIDTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (s_axis_clk),
        .rst   (s_axis_rst),
        .we    (accept_s),
        .waddr (addr_r[RAM_AW-1:0]),
        .wbe   (s_axis_tkeep),
        .wdata (s_axis_tdata),
        .re    (rd_en),
        .raddr (rd_addr[RAM_AW-1:0]),
        .rdata (ram_rdata_s)
    );

    assign s_axis_tready = tready_r;
    assign done          = done_r;
    assign addr_wire     = addr_r;
    assign rd_data       = 64'(ram_rdata_s);

endmodule : ulbf_dout_axis2ram_64b

// File: tb/tb_ulbf_dout_axis2ram_64b.sv
// Self-checking bench for ulbf_dout_axis2ram_64b: randomized capture runs
// compared against a behavioural RAM/address model kept in the bench.
module tb_ulbf_dout_axis2ram_64b;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [11:0] niter;
    logic [11:0] block_size;
    logic [15:0] rollover_addr;
    logic        tvalid;
    logic        tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tready;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [63:0] rd_data;
    logic        done;
    logic [15:0] addr_wire;
    logic [15:0] tlast_err_cnt;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mdl_mem [0:DEPTH-1];

    ulbf_dout_axis2ram_64b #(.RAM_DEPTH(DEPTH), .DATA_WIDTH(64)) dut (
        .s_axis_clk    (clk),
        .s_axis_rst    (rst),
        .go            (go),
        .niter         (niter),
        .block_size    (block_size),
        .rollover_addr (rollover_addr),
        .s_axis_tvalid (tvalid),
        .s_axis_tlast  (tlast),
        .s_axis_tdata  (tdata),
        .s_axis_tkeep  (tkeep),
        .s_axis_tready (tready),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .done          (done),
        .addr_wire     (addr_wire),
        .tlast_err_cnt (tlast_err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int next_addr(input int p, input int roll);
        return ((p == roll) || (p == DEPTH - 1)) ? 0 : p + 1;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] k);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (k[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Read one word through the readback port (enters and leaves at a negedge).
    task automatic read_word(input int a, output logic [63:0] d);
        rd_en = 1'b1; rd_addr = 16'(a);
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
    endtask

    // Drive one capture. vmode: 0 continuous, 1 toggling, 2 random valid/keep
    // with collision reads. dmode: 0 data=dbase+index, 1 random. exp_err<0
    // means use the model's tlast mismatch count.
    task automatic run_capture(input int n, input int bs, input int roll, input int vmode,
                               input int dmode, input logic [63:0] dbase, input bit bad_tlast,
                               input int abort_after, input int exp_err);
        int total, acc, cyc, bib, err_exp, ptr;
        bit v, lastb, pend;
        logic [63:0] d, pend_val;
        logic [7:0] k;
        total = n * bs; acc = 0; cyc = 0; err_exp = 0; ptr = 0; pend = 1'b0; pend_val = '0;
        @(negedge clk);
        niter = 12'(n); block_size = 12'(bs); rollover_addr = 16'(roll); go = 1'b1;
        @(negedge clk);
        checks++;
        if (tready !== 1'b1 || done !== 1'b0 || tlast_err_cnt !== 16'h0) begin
            failures++;
            $display("FAIL run_entry: tready=%b done=%b err=%0d, required tready=1 done=0 err=0", tready, done, tlast_err_cnt);
        end
        if (vmode == 2) go = 1'($urandom_range(0, 1));
        while (acc < total && cyc < 20000) begin
            if (pend) begin
                checks++;
                if (rd_data !== pend_val) begin
                    failures++;
                    $display("FAIL collision_read: got %h, required old data %h", rd_data, pend_val);
                end
            end
            pend = 1'b0;
            checks++;
            if (addr_wire !== 16'(ptr)) begin
                failures++;
                $display("FAIL addr_track: addr_wire=%0d, required %0d", addr_wire, ptr);
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = cyc[0] == 1'b0;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            d = (dmode == 0) ? dbase + 64'(acc) : {$urandom, $urandom};
            k = (vmode == 2) ? 8'($urandom) : 8'hFF;
            bib = acc % bs;
            lastb = (bib == bs - 1);
            tvalid = v; tdata = d; tkeep = k;
            tlast = bad_tlast ? (bib == bs - 2) : lastb;
            rd_en = 1'b0;
            if (v && tready) begin
                if (vmode == 2 && $urandom_range(0, 3) == 0) begin
                    rd_en = 1'b1; rd_addr = 16'(ptr); pend = 1'b1; pend_val = mdl_mem[ptr];
                end
                mdl_mem[ptr] = merge(mdl_mem[ptr], d, k);
                if ((tlast != lastb) && err_exp < 65535) err_exp++;
                ptr = next_addr(ptr, roll);
                acc++;
            end
            @(negedge clk);
            cyc++;
            if (abort_after != 0 && acc == abort_after) return;
        end
        rd_en = 1'b0;
        if (pend) begin
            checks++;
            if (rd_data !== pend_val) begin
                failures++;
                $display("FAIL collision_read: got %h, required old data %h", rd_data, pend_val);
            end
        end
        if (cyc >= 20000) begin
            checks++; failures++;
            $display("FAIL capture_timeout: accepted %0d beats, required %0d", acc, total);
        end
        // Offer junk beats in DONE: they must not be written.
        tvalid = 1'b1; tdata = 64'hDEAD_BEEF_DEAD_BEEF; tkeep = 8'hFF;
        checks++;
        if (tready !== 1'b0 || done !== 1'b1 || addr_wire !== 16'(ptr)) begin
            failures++;
            $display("FAIL run_end: tready=%b done=%b addr=%0d, required tready=0 done=1 addr=%0d", tready, done, addr_wire, ptr);
        end
        if (exp_err < 0) begin
`ifdef ULBF_TLAST_CHECK_EN
            exp_err = err_exp;
`else
            exp_err = 0;
`endif
        end
        checks++;
        if (tlast_err_cnt !== 16'(exp_err)) begin
            failures++;
            $display("FAIL tlast_err_cnt: got %0d, required %0d", tlast_err_cnt, exp_err);
        end
        go = 1'b0;
        @(negedge clk);
        tvalid = 1'b0;
        checks++;
        if (done !== 1'b0 || addr_wire !== 16'h0 || tready !== 1'b0) begin
            failures++;
            $display("FAIL done_exit: done=%b addr=%0d tready=%b, required 0 0 0", done, addr_wire, tready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; niter = '0; block_size = '0; rollover_addr = '0;
        tvalid = 1'b0; tlast = 1'b0; tdata = '0; tkeep = '0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (tready !== 1'b0 || done !== 1'b0 || addr_wire !== 16'h0 || rd_data !== 64'h0 || tlast_err_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: tready=%b done=%b addr=%0d rd=%h err=%0d, required all zero", tready, done, addr_wire, rd_data, tlast_err_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [63:0] d;
        int a;
        run_capture(1, DEPTH, 16'hFFFF, 0, 1, 64'h0, 1'b0, 0, -1);
        for (int i = 0; i < 32; i++) begin
            a = (i < 2) ? i * (DEPTH - 1) : int'($urandom_range(0, DEPTH - 1));
            read_word(a, d);
            checks++;
            if (d !== mdl_mem[a]) begin
                failures++;
                $display("FAIL fill_read[%0d]: got %h, required %h", a, d, mdl_mem[a]);
            end
        end
    endtask

    task automatic test_basic();
        logic [63:0] d;
        run_capture(2, 4, 16'hFFFF, 0, 0, 64'h0, 1'b0, 0, -1);
        for (int i = 0; i < 9; i++) begin
            read_word(i, d);
            checks++;
            if (d !== ((i < 8) ? 64'(i) : mdl_mem[8])) begin
                failures++;
                $display("FAIL basic_read[%0d]: got %h", i, d);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d;
        run_capture(2, 4, 16'hFFFF, 1, 0, 64'h100, 1'b0, 0, -1);
        for (int i = 0; i < 9; i++) begin
            read_word(i, d);
            checks++;
            if (d !== ((i < 8) ? 64'h100 + 64'(i) : mdl_mem[8])) begin
                failures++;
                $display("FAIL gap_read[%0d]: got %h", i, d);
            end
        end
    endtask

    task automatic test_rollover();
        logic [63:0] d;
        logic [63:0] exp_v [0:3];
        exp_v[0] = 64'hA4; exp_v[1] = 64'hA5; exp_v[2] = 64'hA2; exp_v[3] = 64'hA3;
        run_capture(1, 6, 3, 0, 0, 64'hA0, 1'b0, 0, -1);
        for (int i = 0; i < 5; i++) begin
            read_word(i, d);
            checks++;
            if (d !== ((i < 4) ? exp_v[i] : mdl_mem[4])) begin
                failures++;
                $display("FAIL rollover_read[%0d]: got %h", i, d);
            end
        end
    endtask

    task automatic test_zero_size();
        logic [63:0] d;
        bit seen;
        for (int z = 0; z < 2; z++) begin
            seen = 1'b0;
            @(negedge clk);
            niter = (z == 0) ? 12'd0 : 12'd3; block_size = (z == 0) ? 12'd4 : 12'd0;
            go = 1'b1; tvalid = 1'b1; tkeep = 8'hFF; tdata = 64'h5A5A;
            @(negedge clk);
            checks++;
            if (done !== 1'b1) begin
                failures++;
                $display("FAIL zero_done[%0d]: done=%b, required 1", z, done);
            end
            repeat (3) begin
                seen = seen | tready;
                @(negedge clk);
            end
            checks++;
            if (seen || tready !== 1'b0) begin
                failures++;
                $display("FAIL zero_tready[%0d]: tready seen high, required never", z);
            end
            go = 1'b0; tvalid = 1'b0;
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL zero_exit[%0d]: done=%b, required 0", z, done);
            end
        end
        for (int i = 0; i < 4; i++) begin
            read_word(i, d);
            checks++;
            if (d !== mdl_mem[i]) begin
                failures++;
                $display("FAIL zero_ram[%0d]: got %h, required %h", i, d, mdl_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] d;
        run_capture(1, 8, 16'hFFFF, 0, 1, 64'h0, 1'b0, 3, -1);
        rst = 1'b1;
        #1;
        checks++;
        if (tready !== 1'b0 || done !== 1'b0 || addr_wire !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid: tready=%b done=%b addr=%0d, required 0 0 0", tready, done, addr_wire);
        end
        tvalid = 1'b0; go = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: done=%b tready=%b, required 0 0", done, tready);
        end
        for (int i = 0; i < 5; i++) begin
            read_word(i, d);
            checks++;
            if (d !== mdl_mem[i]) begin
                failures++;
                $display("FAIL reset_ram[%0d]: got %h, required %h", i, d, mdl_mem[i]);
            end
        end
        run_capture(1, 4, 16'hFFFF, 0, 1, 64'h0, 1'b0, 0, -1);
        read_word(0, d);
        checks++;
        if (d !== mdl_mem[0]) begin
            failures++;
            $display("FAIL restart_addr0: got %h, required %h", d, mdl_mem[0]);
        end
    endtask

    task automatic test_tlast();
`ifdef ULBF_TLAST_CHECK_EN
        run_capture(1, 4, 16'hFFFF, 0, 1, 64'h0, 1'b1, 0, 2);
`else
        run_capture(1, 4, 16'hFFFF, 0, 1, 64'h0, 1'b1, 0, 0);
`endif
        run_capture(2, 5, 16'hFFFF, 1, 1, 64'h0, 1'b1, 0, -1);
    endtask

    task automatic test_random();
        logic [63:0] d;
        int n, bs, roll;
        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, 3));
            bs = int'($urandom_range(1, 20));
            roll = ($urandom_range(0, 1) == 0) ? 16'hFFFF : int'($urandom_range(0, 40));
            run_capture(n, bs, roll, 2, 1, 64'h0, 1'($urandom_range(0, 1)), 0, -1);
            for (int i = 0; i < 64; i++) begin
                read_word(i, d);
                checks++;
                if (d !== mdl_mem[i]) begin
                    failures++;
                    $display("FAIL random_read[%0d][%0d]: got %h, required %h", t, i, d, mdl_mem[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_backpressure();
        test_rollover();
        test_zero_size();
        test_reset_mid_run();
        test_tlast();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ulbf_dout_axis2ram_64b
